// File: rtl/div_mini_pkg.sv
// Shared types and default widths for the iterative divider mini-block.
//   DW_DIVIDEND_DEF : default dividend/quotient width (also the iteration count)
//   DW_DIVISOR_DEF  : default divisor/remainder width
//   div_state_t     : controller states IDLE, BUSY, DONE
package div_mini_pkg;

  localparam int DW_DIVIDEND_DEF = 16;
  localparam int DW_DIVISOR_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// Single combinational restoring-division step.
// Ports:
//   pr       in  DW_DIVISOR+1  current partial remainder
//   next_bit in  1             next dividend bit, shifted into the LSB of pr
//   divisor  in  DW_DIVISOR    unsigned divisor
//   pr_next  out DW_DIVISOR+1  partial remainder after the step
//   qbit     out 1             quotient bit produced by this step
module div_step
  import div_mini_pkg::*;
#(
  parameter int DW_DIVISOR = DW_DIVISOR_DEF
) (
  input  logic [DW_DIVISOR:0]   pr,
  input  logic                  next_bit,
  input  logic [DW_DIVISOR-1:0] divisor,
  output logic [DW_DIVISOR:0]   pr_next,
  output logic                  qbit
);

  logic [DW_DIVISOR:0] shifted;
  logic [DW_DIVISOR:0] dvsr_ext;

  // pr is always < divisor on entry, so the shifted value fits in RW+1 bits.
  always_comb begin
    shifted  = {pr[DW_DIVISOR-1:0], next_bit};
    dvsr_ext = {1'b0, divisor};
    qbit     = (shifted >= dvsr_ext);
    pr_next  = qbit ? (shifted - dvsr_ext) : shifted;
  end

endmodule

// File: rtl/div_iterative_mini.sv
// Sequential restoring divider: 16-bit dividend / 8-bit divisor -> 16-bit
// quotient, 8-bit remainder, one quotient bit per cycle, valid/ready on both sides.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE)
//   dividend, divisor    unsigned operands
//   out_valid / out_ready result handshake (result held while out_ready=0)
//   quotient, remainder  unsigned result
//   dbz                  divide-by-zero flag, qualified by out_valid
// Divide by zero falls out of the restoring loop: quotient all ones,
// remainder = dividend[RW-1:0].
// Optional macro DIV_EARLY_OUT_EN: when divisor==0 or dividend<divisor the
// result is loaded directly on the accept edge (latency 1 instead of DW_DIVIDEND+1).
module div_iterative_mini
  import div_mini_pkg::*;
#(
  parameter int DW_DIVIDEND = DW_DIVIDEND_DEF,
  parameter int DW_DIVISOR  = DW_DIVISOR_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW_DIVIDEND-1:0] dividend,
  input  logic [DW_DIVISOR-1:0]  divisor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW_DIVIDEND-1:0] quotient,
  output logic [DW_DIVISOR-1:0]  remainder,
  output logic                   dbz
);

  localparam int QW = DW_DIVIDEND;
  localparam int RW = DW_DIVISOR;
  localparam int CW = $clog2(QW + 1);

  div_state_t      state, state_next;
  logic [CW-1:0]   cnt;
  logic [QW-1:0]   dq;
  logic [RW:0]     pr;
  logic [RW-1:0]   dvsr;
  logic [RW:0]     pr_step;
  logic            qbit;
  logic            accept;
  logic            last_step;
  logic            early;

  assign accept    = in_valid && (state == IDLE);
  assign last_step = (state == BUSY) && (cnt == CW'(1));

`ifdef DIV_EARLY_OUT_EN
  // Trivial results need no iteration: quotient is 0 or all ones.
  assign early = (divisor == '0) || (dividend < {{(QW-RW){1'b0}}, divisor});
`else
  assign early = 1'b0;
`endif

  div_step #(
    .DW_DIVISOR (RW)
  ) u_step (
    .pr       (pr),
    .next_bit (dq[QW-1]),
    .divisor  (dvsr),
    .pr_next  (pr_step),
    .qbit     (qbit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = early ? DONE : BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else if (accept) begin
      cnt <= CW'(QW);
      dbz <= (divisor == '0);
`ifdef DIV_EARLY_OUT_EN
      if (early) begin
        quotient  <= (divisor == '0) ? '1 : '0;
        remainder <= dividend[RW-1:0];
      end
`endif
    end else if (state == BUSY) begin
      cnt <= cnt - CW'(1);
      if (last_step) begin
        quotient  <= {dq[QW-2:0], qbit};
        remainder <= pr_step[RW-1:0];
      end
    end
  end

  // Iteration datapath: dividend shifts out of dq while quotient bits shift in
  always_ff @(posedge clk) begin
    if (accept) begin
      dq   <= dividend;
      dvsr <= divisor;
      pr   <= '0;
    end else if (state == BUSY) begin
      dq <= {dq[QW-2:0], qbit};
      pr <= pr_step;
    end
  end

endmodule
